dmem_access_ctrl: RTL
=====================

# dmem_access_ctrl

Data-memory access controller in the MEM stage, between the load/store formatting logic and the data-memory bus. It takes one lane-aligned load or store request per instruction and runs a valid/ready request and response exchange on the bus. While the access is outstanding it stalls the pipeline. It then returns the raw 32-bit read word, which the load formatter sign- or zero-extends in WB, together with error status.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of WAIT cycles without a bus response before the access aborts with a timeout.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  MEM stage holds a load or store; held stable until `stall_o` is low.
- `req_we`  in  1  1 = store, 0 = load (sl_type[3]).
- `req_size`  in  2  01 = byte, 10 = half, 11 = word (sl_type[1:0]).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, already placed in its byte lanes.
- `req_wstrb`  in  4  byte write enables; ignored for loads.
- `stall_o`  out  1  freezes the pipeline while the access is incomplete.
- `rsp_valid_o`  out  1  one-cycle pulse: access complete.
- `rsp_rdata_o`  out  32  raw read word, valid with `rsp_valid_o` on loads; 0 on stores and errors.
- `err_o`  out  1  pulse with `rsp_valid_o` when the access failed.
- `err_code_o`  out  2  00 none, 01 bus error, 10 timeout, 11 misaligned.
- `bus_req_valid`  out  1  request valid.
- `bus_req_ready`  in  1  request accepted.
- `bus_addr`  out  32  word-aligned address {req_addr[31:2], 2'b00}.
- `bus_we`, `bus_wstrb`[4], `bus_wdata`[32]  out  registered copies of the request.
- `bus_rsp_valid`  in  1  response or store acknowledge.
- `bus_rsp_rdata`  in  32  read data.
- `bus_rsp_err`  in  1  bus error flag, qualified by `bus_rsp_valid`.

## Operation
- The controller has four states: IDLE, REQ, WAIT and DONE.
- **IDLE**
  - With `req_valid`=1, latch addr, we, wstrb and wdata, then go to REQ.
  - `stall_o` is 1 combinationally in this cycle.
- **REQ**
  - `bus_req_valid`=1, with all bus fields stable.
  - On `bus_req_ready`=1, go to WAIT and clear the timeout counter.
- **WAIT**
  - `bus_rsp_valid` is sampled only in this state.
  - On `bus_rsp_valid`=1, capture the data (loads only) and the error flag, then go to DONE.
  - Otherwise increment the 8-bit counter. When it reaches `TIMEOUT_CYCLES`, go to DONE with code 10.
- **DONE**
  - `rsp_valid_o`=1, `stall_o`=0 and `err_o`/`err_code_o` are driven from the captured status; the MEM instruction advances at this edge.
  - Next state is always IDLE.
- Stores also wait for `bus_rsp_valid`, which acts as the write acknowledge; `rsp_rdata_o`=0 for stores.
- `stall_o` = (IDLE && `req_valid`) || REQ || WAIT.
- A late `bus_rsp_valid` arriving in IDLE, REQ or DONE is ignored.

## Timing
- Reset values: state IDLE; every output 0; captured registers and counter 0.
- The asynchronous reset in REQ or WAIT drops `bus_req_valid` immediately.
- Minimum latency is 4 cycles:
  - T0: IDLE accepts the request.
  - T1: REQ, with `bus_req_ready` = 1 in the same cycle.
  - T2: WAIT, with `bus_rsp_valid` = 1.
  - T3: DONE.
- Each extra cycle of ready low or response delay adds one stall cycle.
- Throughput is one access per 4 cycles at best; back-to-back requests re-enter IDLE between them.
- A timeout fires after exactly `TIMEOUT_CYCLES` WAIT cycles. The counter saturates and does not wrap.
- `bus_rsp_valid` and the timeout in the same cycle: the response wins.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - In IDLE, half with addr[0]=1 or word with addr[1:0]≠00 is misaligned.
  - A misaligned request goes straight to DONE: no bus transaction, `err_o`=1, code 11, latency 2 cycles.
- `MISALIGN_TRAP_EN` undefined:
  - No alignment check.
  - Address low bits are dropped on the bus and the access proceeds using the given wstrb.

## Structure
- The state enum `dmem_state_t` and the error-code constants live in the shared package `mem_pkg`, next to the existing MEM_* access-type encodings.
- One sub-module, `dmem_timeout_cnt`, holds the saturating counter with clear/enable and its expiry flag.

## Test plan
- Load word, addr 0x100, ready and response immediate, rdata 0xDEADBEEF -> `rsp_valid_o` at T3 with 0xDEADBEEF; `stall_o` high for T0–T2.
- Store byte, addr 0x103, wstrb 1000, ready delayed 3 cycles -> `bus_addr` 0x100 and `bus_wstrb` 1000 held stable; `rsp_valid_o` at T6; `rsp_rdata_o` 0.
- No response, `TIMEOUT_CYCLES`=4 -> DONE after 4 WAIT cycles with `err_o`=1 and code 10; a later `bus_rsp_valid` is ignored.
- Response with `bus_rsp_err`=1 -> `err_o`=1, code 01, `rsp_rdata_o`=0.
- With `MISALIGN_TRAP_EN`, load word at 0x102 -> no `bus_req_valid`; DONE at T1 with code 11. Without the macro -> normal access to 0x100.
- `rst_n` asserted in WAIT -> all outputs 0 immediately; after release, the controller is in IDLE and a new request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared MEM-stage definitions: load/store access-size encodings (sl_type[1:0]),
// data-memory error codes, the dmem_access_ctrl state enum, and an alignment
// helper used when the misalignment trap is built in.
// -----------------------------------------------------------------------------
package mem_pkg;

    // Access size, as carried in sl_type[1:0]
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_WORD = 2'b11;

    // Completion status reported with rsp_valid_o
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_MISALIGN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } dmem_state_t;

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=00.
    function automatic logic mem_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == MEM_HALF && addr_lo[0])       mis = 1'b1;
        if (size == MEM_WORD && addr_lo != 2'b00) mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// -----------------------------------------------------------------------------
// dmem_timeout_cnt
// 8-bit saturating WAIT-cycle counter for the data-memory access controller.
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset (count -> 0)
//   clr_i     synchronous clear (takes priority over en_i)
//   en_i      count one WAIT cycle without a response
//   cnt_o     current count
//   expire_o  this enabled cycle is the LIMIT-th one (count + 1 >= LIMIT)
// -----------------------------------------------------------------------------
module dmem_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [7:0] cnt_o,
    output logic       expire_o
);

    localparam logic [8:0] LIMIT_W = 9'(LIMIT);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && cnt_q != 8'hFF) begin
            // Saturate instead of wrapping so a stuck bus can never look fresh.
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looks one cycle ahead: the cycle that would bring the count to LIMIT
    // is the last WAIT cycle, so the FSM leaves WAIT at that edge.
    assign expire_o = en_i && (({1'b0, cnt_q} + 9'd1) >= LIMIT_W);
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage data-memory access controller. Accepts one lane-aligned load or
// store, runs a request/response exchange on the data bus, stalls the
// pipeline while the access is outstanding, then pulses rsp_valid_o with the
// raw read word and error status.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   -> misaligned half/word requests complete at once with code 11
//                and never reach the bus
//   undefined -> no alignment check; low address bits are dropped on the bus
//
// Handshakes:
//   bus request : bus_req_valid is held high with every bus_* field stable
//                 until the cycle bus_req_ready is high; the transfer happens
//                 at that rising edge and bus_req_valid drops the next cycle.
//   bus response: bus_rsp_valid (with rdata/err) is only honoured in WAIT;
//                 it is a one-cycle acknowledge and needs no ready.
//   pipeline    : req_valid is held with its fields until stall_o is low;
//                 rsp_valid_o pulses for exactly that one cycle.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/we/size/addr/wdata/wstrb   request from the MEM stage
//   stall_o                         pipeline freeze
//   rsp_valid_o, rsp_rdata_o        completion pulse and raw read word
//   err_o, err_code_o               completion status
//   bus_req_valid/ready, bus_addr, bus_we, bus_wstrb, bus_wdata   bus request
//   bus_rsp_valid, bus_rsp_rdata, bus_rsp_err                     bus response
//   state_o                         current FSM state (debug)
// -----------------------------------------------------------------------------
module dmem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,

    output logic        stall_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,

    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err,

    output dmem_state_t state_o
);

    dmem_state_t state_q, state_d;

    logic [31:0] addr_q,  addr_d;
    logic        we_q,    we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic [1:0]  code_q,  code_d;

    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_expire;
    logic [7:0]  cnt_val;

    dmem_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .cnt_o    (cnt_val),
        .expire_o (cnt_expire)
    );

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        code_d  = code_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    // Fresh status for this access.
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
`ifdef MISALIGN_TRAP_EN
                    if (mem_misaligned(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        code_d  = ERR_MISALIGN;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end

            ST_REQ: begin
                if (bus_req_ready) begin
                    cnt_clr = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A response in the same cycle as expiry wins: check it first.
                if (bus_rsp_valid) begin
                    rdata_d = (!we_q && !bus_rsp_err) ? bus_rsp_rdata : 32'd0;
                    err_d   = bus_rsp_err;
                    code_d  = bus_rsp_err ? ERR_BUS : ERR_NONE;
                    state_d = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_expire) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Outputs decode straight from registered state so the async reset
    // clears them (including bus_req_valid) without waiting for a clock.
    logic in_done;
    assign in_done = (state_q == ST_DONE);

    assign stall_o       = ((state_q == ST_IDLE) && req_valid)
                         || (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign rsp_valid_o   = in_done;
    assign rsp_rdata_o   = in_done ? rdata_q : 32'd0;
    assign err_o         = in_done & err_q;
    assign err_code_o    = in_done ? code_q : ERR_NONE;

    assign bus_req_valid = (state_q == ST_REQ);
    assign bus_addr      = {addr_q[31:2], 2'b00};
    assign bus_we        = we_q;
    assign bus_wstrb     = wstrb_q;
    assign bus_wdata     = wdata_q;

    assign state_o       = state_q;

    // Size only matters to the alignment check; the count is observed
    // through expire_o alone.
    logic unused_ok;
    assign unused_ok = ^{req_size, cnt_val};

endmodule
